// File: rtl/lcd_bus_responder.sv
// rtl/lcd_bus_responder.sv - HD44780-subset responder on the 8-bit LCD bus.
// Optional read-back (busy flag / data read) is enabled by defining LCD_READ_EN.
module lcd_bus_responder #(
    parameter int BUSY_SHORT = 1850,
    parameter int BUSY_LONG  = 76000,
    parameter int CNT_W      = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  lcd_data,
    input  logic        lcd_rs,
    input  logic        lcd_rw,
    input  logic        lcd_en,
    input  logic [4:0]  rd_addr,
    output logic [7:0]  rd_char,
    output logic        busy,
    output logic [4:0]  cursor,
    output logic        display_on,
    output logic        two_line,
    output logic [15:0] cmd_count,
    output logic        err_busy,
    output logic        err_addr,
    output logic        err_read,
    output logic [7:0]  lcd_data_out,
    output logic        lcd_data_oe
);

    typedef enum logic [1:0] {S_IDLE, S_DECODE, S_EXEC, S_BUSY} state_t;
    typedef enum logic [3:0] {
        K_NOP, K_CLEAR, K_HOME, K_ENTRY, K_DISP, K_SHIFT,
        K_FUNC, K_DDADDR, K_WRITE, K_READ
    } kind_t;

    state_t           state;
    kind_t            kind;
    logic             en_q;
    logic             cap_rs, cap_rw;
    logic [7:0]       cap_d;
    logic             tx_rs, tx_rw;
    logic [7:0]       tx_d;
    logic [4:0]       ac;
    logic             id_bit;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       mem [32];
    logic             fall;
    logic             read_ok;

    assign fall   = en_q & ~lcd_en;
    assign busy   = (state != S_IDLE);
    assign cursor = ac;

`ifdef LCD_READ_EN
    logic [7:0] rd_latch;
    assign read_ok      = cap_rs;
    assign lcd_data_oe  = lcd_en & lcd_rw;
    assign lcd_data_out = lcd_rs ? rd_latch : {busy, 2'b00, ac};
`else
    assign read_ok      = 1'b0;
    assign lcd_data_oe  = 1'b0;
    assign lcd_data_out = 8'h00;
`endif

    // Instruction priority follows the highest set bit of the opcode byte.
    function automatic kind_t classify(input logic rs, input logic rw, input logic [7:0] d);
        if (rw)
            return K_READ;
        if (rs)
            return K_WRITE;
        casez (d)
            8'b1???????: return K_DDADDR;
            8'b01??????: return K_NOP;
            8'b001?????: return K_FUNC;
            8'b0001????: return K_SHIFT;
            8'b00001???: return K_DISP;
            8'b000001??: return K_ENTRY;
            8'b0000001?: return K_HOME;
            8'b00000001: return K_CLEAR;
            default:     return K_NOP;
        endcase
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            kind       <= K_NOP;
            en_q       <= 1'b0;
            cap_rs     <= 1'b0;
            cap_rw     <= 1'b0;
            cap_d      <= 8'h00;
            tx_rs      <= 1'b0;
            tx_rw      <= 1'b0;
            tx_d       <= 8'h00;
            ac         <= 5'd0;
            id_bit     <= 1'b1;
            cnt        <= '0;
            rd_char    <= 8'h20;
            display_on <= 1'b0;
            two_line   <= 1'b0;
            cmd_count  <= 16'h0000;
            err_busy   <= 1'b0;
            err_addr   <= 1'b0;
            err_read   <= 1'b0;
`ifdef LCD_READ_EN
            rd_latch   <= 8'h00;
`endif
            for (int i = 0; i < 32; i++)
                mem[i] <= 8'h20;
        end else begin
            en_q    <= lcd_en;
            rd_char <= mem[rd_addr];
            if (lcd_en) begin
                cap_rs <= lcd_rs;
                cap_rw <= lcd_rw;
                cap_d  <= lcd_data;
            end

            // Reads never collide with the write pipeline; writes while busy are dropped.
            if (fall) begin
                if (cap_rw) begin
`ifdef LCD_READ_EN
                    if (cap_rs) begin
                        rd_latch <= mem[ac];
                        ac       <= id_bit ? ac + 5'd1 : ac - 5'd1;
                    end
`else
                    err_read <= 1'b1;
`endif
                end else if (state != S_IDLE) begin
                    err_busy <= 1'b1;
                end
            end

            case (state)
                S_IDLE: begin
                    if (fall && (!cap_rw || read_ok)) begin
                        tx_rs <= cap_rs;
                        tx_rw <= cap_rw;
                        tx_d  <= cap_d;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    kind  <= classify(tx_rs, tx_rw, tx_d);
                    state <= S_EXEC;
                end
                S_EXEC: begin
                    cnt <= CNT_W'(BUSY_SHORT);
                    case (kind)
                        K_CLEAR: begin
                            for (int i = 0; i < 32; i++)
                                mem[i] <= 8'h20;
                            ac     <= 5'd0;
                            id_bit <= 1'b1;
                            cnt    <= CNT_W'(BUSY_LONG);
                        end
                        K_HOME: begin
                            ac  <= 5'd0;
                            cnt <= CNT_W'(BUSY_LONG);
                        end
                        K_ENTRY: id_bit     <= tx_d[1];
                        K_DISP:  display_on <= tx_d[2];
                        K_SHIFT: begin
                            if (!tx_d[3])
                                ac <= tx_d[2] ? ac + 5'd1 : ac - 5'd1;
                        end
                        K_FUNC:  two_line <= tx_d[3];
                        K_DDADDR: begin
                            ac <= {tx_d[6], tx_d[3:0]};
                            if (tx_d[5:4] != 2'b00)
                                err_addr <= 1'b1;
                        end
                        K_WRITE: begin
                            mem[ac] <= tx_d;
                            ac      <= id_bit ? ac + 5'd1 : ac - 5'd1;
                        end
                        default: ;
                    endcase
                    if (cmd_count != 16'hFFFF)
                        cmd_count <= cmd_count + 16'd1;
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    cnt <= cnt - CNT_W'(1);
                    if (cnt <= CNT_W'(1))
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_bus_responder.sv
// tb/tb_lcd_bus_responder.sv - scoreboard bench for lcd_bus_responder (LCD_READ_EN undefined).
module tb_lcd_bus_responder;

    localparam int BS = 20;
    localparam int BL = 200;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  lcd_data;
    logic        lcd_rs, lcd_rw, lcd_en;
    logic [4:0]  rd_addr;
    logic [7:0]  rd_char;
    logic        busy;
    logic [4:0]  cursor;
    logic        display_on, two_line;
    logic [15:0] cmd_count;
    logic        err_busy, err_addr, err_read;
    logic [7:0]  lcd_data_out;
    logic        lcd_data_oe;

    lcd_bus_responder #(.BUSY_SHORT(BS), .BUSY_LONG(BL), .CNT_W(17)) dut (
        .clk(clk), .reset(reset), .lcd_data(lcd_data), .lcd_rs(lcd_rs),
        .lcd_rw(lcd_rw), .lcd_en(lcd_en), .rd_addr(rd_addr), .rd_char(rd_char),
        .busy(busy), .cursor(cursor), .display_on(display_on), .two_line(two_line),
        .cmd_count(cmd_count), .err_busy(err_busy), .err_addr(err_addr),
        .err_read(err_read), .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int exp_busy_q[$];
    logic [7:0] m_mem [32];
    logic [4:0] m_ac;
    logic       m_id;
    int         m_cmd;
    int         run = 0;

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Each busy phase is popped against the length queued when its transaction was driven.
    always @(negedge clk) begin
        if (reset)
            run = 0;
        else if (busy)
            run++;
        else if (run > 0) begin
            if (exp_busy_q.size() == 0)
                check("busy_unexpected", run, 0);
            else
                check("busy_len", run, exp_busy_q.pop_front());
            run = 0;
        end
    end

    task automatic model_reset();
        foreach (m_mem[i]) m_mem[i] = 8'h20;
        m_ac  = 5'd0;
        m_id  = 1'b1;
        m_cmd = 0;
    endtask

    task automatic pulse(logic rs, logic rw, logic [7:0] d);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < BL + 50) begin
            @(negedge clk);
            n++;
        end
        if (busy)
            check("wait_idle_timeout", busy, 0);
        @(negedge clk);
    endtask

    task automatic wr_start(logic rs, logic [7:0] d);
        int len = BS + 2;
        if (rs) begin
            m_mem[m_ac] = d;
            m_ac = m_id ? m_ac + 5'd1 : m_ac - 5'd1;
        end else begin
            casez (d)
                8'b1???????: m_ac = {d[6], d[3:0]};
                8'b0001????: if (!d[3]) m_ac = d[2] ? m_ac + 5'd1 : m_ac - 5'd1;
                8'b000001??: m_id = d[1];
                8'b0000001?: begin m_ac = 5'd0; len = BL + 2; end
                8'b00000001: begin
                    foreach (m_mem[i]) m_mem[i] = 8'h20;
                    m_ac = 5'd0; m_id = 1'b1; len = BL + 2;
                end
                default: ;
            endcase
        end
        m_cmd++;
        exp_busy_q.push_back(len);
        pulse(rs, 1'b0, d);
    endtask

    task automatic wr(logic rs, logic [7:0] d);
        wr_start(rs, d);
        wait_idle();
    endtask

    task automatic probe(int a, logic [7:0] exp);
        @(negedge clk);
        rd_addr = a[4:0];
        @(negedge clk);
        check($sformatf("rd_char[%0d]", a), rd_char, exp);
    endtask

    task automatic probe_all();
        for (int a = 0; a < 32; a++)
            probe(a, m_mem[a]);
    endtask

    initial begin
        int saw_busy;
        reset = 1'b1; lcd_data = 8'h00; lcd_rs = 1'b0; lcd_rw = 1'b0; lcd_en = 1'b0;
        rd_addr = 5'd0;
        model_reset();
        repeat (3) @(negedge clk);
        check("rst_rd_char", rd_char, 8'h20);
        reset = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_cursor", cursor, 0);
        check("rst_cmd", cmd_count, 0);
        check("rst_flags", {display_on, two_line, err_busy, err_addr, err_read}, 0);
        probe_all();

        wr(0, 8'h38); wr(0, 8'h0C); wr(0, 8'h06); wr(1, 8'h48); wr(1, 8'h49);
        check("two_line", two_line, 1);
        check("display_on", display_on, 1);
        check("cursor_hi", cursor, m_ac);
        check("cmd_hi", cmd_count, m_cmd);
        check("err_busy_clean", err_busy, 0);
        probe(0, 8'h48);
        probe(1, 8'h49);

        wr(0, 8'hCF); wr(1, 8'h41); wr(1, 8'h42);
        probe(31, 8'h41);
        probe(0, 8'h42);
        check("cursor_wrap", cursor, 1);
        check("err_addr_clean", err_addr, 0);
        wr(0, 8'h90);
        check("err_addr", err_addr, 1);
        check("cursor_badaddr", cursor, 0);

        wr(0, 8'h04); wr(1, 8'h43);
        check("cursor_dec_wrap", cursor, m_ac);
        probe(0, 8'h43);
        wr(0, 8'h14);
        check("cursor_shift", cursor, m_ac);
        wr(0, 8'h06);

        wr_start(0, 8'h01);
        repeat (100) @(negedge clk);
        pulse(1, 1'b0, 8'h55);
        wait_idle();
        check("err_busy", err_busy, 1);
        check("cursor_clear", cursor, 0);
        check("cmd_clear", cmd_count, m_cmd);
        probe_all();

        @(negedge clk);
        lcd_rs = 1'b1; lcd_rw = 1'b1; lcd_en = 1'b1;
        @(negedge clk);
        check("rd_oe_off", lcd_data_oe, 0);
        check("rd_out_off", lcd_data_out, 0);
        @(negedge clk);
        lcd_en = 1'b0;
        saw_busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) saw_busy = 1;
        end
        check("read_no_busy", saw_busy, 0);
        check("err_read", err_read, 1);
        check("cmd_read", cmd_count, m_cmd);

        wr(1, 8'h31); wr(0, 8'h02);
        check("cursor_home", cursor, 0);
        probe(0, 8'h31);

        pulse(1, 1'b0, 8'h5A);
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", busy, 1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        check("mid_cmd", cmd_count, 0);
        check("mid_busy_rst", busy, 0);
        check("mid_cursor", cursor, 0);
        probe(0, 8'h20);
        repeat (BS + 10) @(negedge clk);
        check("mid_still_idle", busy, 0);
        probe(0, 8'h20);

        check("sb_empty", exp_busy_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
